// File: rtl/apb_master_arb_if.sv
// APB3 bus bundle between apb_master_arb (master side) and the slave fabric.
interface apb_master_arb_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [DW-1:0] prdata;
    logic          pready;
    logic          pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_master_arb.sv
// Round-robin arbiter sharing one APB3 bus between NREQ requesters, one transfer at a time.
// Optional ACCESS-phase watchdog enabled with macro APB_ARB_TIMEOUT_EN.
module apb_master_arb #(
    parameter int NREQ    = 4,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ-1:0]    req_write,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]    done,
    output logic [DW-1:0]      rdata,
    output logic               err,
    apb_master_arb_if.master   apb
);
    localparam int GW = $clog2(NREQ);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t          state_r;
    state_t          next_state_s;
    logic [GW-1:0]   last_grant_r;
    logic [GW-1:0]   grant_r;
    logic [GW-1:0]   win_idx_s;
    logic [GW-1:0]   cand_s;
    logic            win_valid_s;
    logic            complete_s;
    logic            timeout_s;
    logic [NREQ-1:0] eligible_s;
    logic [NREQ-1:0] done_r;
    logic            psel_r;
    logic            penable_r;
    logic            pwrite_r;
    logic [AW-1:0]   paddr_r;
    logic [DW-1:0]   pwdata_r;
    logic [DW-1:0]   rdata_r;
    logic            err_r;

    // A requester whose done is high this cycle is masked so it cannot be re-granted stale.
    assign eligible_s = req & ~done_r;

    // Round-robin search beginning one past the last grant, wrapping at NREQ-1.
    always_comb begin
        win_valid_s = 1'b0;
        win_idx_s   = {GW{1'b0}};
        cand_s      = last_grant_r;
        for (int k = 0; k < NREQ; k++) begin
            if (cand_s == GW'(NREQ - 1)) begin
                cand_s = {GW{1'b0}};
            end else begin
                cand_s = cand_s + GW'(1);
            end
            if (!win_valid_s && eligible_s[cand_s]) begin
                win_valid_s = 1'b1;
                win_idx_s   = cand_s;
            end else begin
                win_valid_s = win_valid_s;
            end
        end
    end

`ifdef APB_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tcnt_r;

    // Fires in the TIMEOUT-th consecutive ACCESS cycle with pready still low.
    assign timeout_s = (state_r == ACCESS) && !apb.pready && (tcnt_r == TW'(TIMEOUT - 1));

    // Wait-state counter, restarted for every transfer in SETUP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tcnt_r <= {TW{1'b0}};
        end else if (state_r == SETUP) begin
            tcnt_r <= {TW{1'b0}};
        end else if (state_r == ACCESS && !apb.pready) begin
            tcnt_r <= tcnt_r + TW'(1);
        end else begin
            tcnt_r <= tcnt_r;
        end
    end
`else
    // Watchdog compiled out: ACCESS waits on pready indefinitely.
    assign timeout_s = (TIMEOUT < 0);
`endif

    // Next-state decode for the IDLE/SETUP/ACCESS phase sequencer.
    always_comb begin
        next_state_s = state_r;
        complete_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (win_valid_s) begin
                    next_state_s = SETUP;
                end else begin
                    next_state_s = IDLE;
                end
            end
            SETUP: begin
                next_state_s = ACCESS;
            end
            ACCESS: begin
                if (apb.pready || timeout_s) begin
                    next_state_s = IDLE;
                    complete_s   = 1'b1;
                end else begin
                    next_state_s = ACCESS;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Phase state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Bus outputs, grant capture at the arbitration point, and completion reporting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_r <= GW'(NREQ - 1);
            grant_r      <= {GW{1'b0}};
            psel_r       <= 1'b0;
            penable_r    <= 1'b0;
            pwrite_r     <= 1'b0;
            paddr_r      <= {AW{1'b0}};
            pwdata_r     <= {DW{1'b0}};
            done_r       <= {NREQ{1'b0}};
            rdata_r      <= {DW{1'b0}};
            err_r        <= 1'b0;
        end else begin
            psel_r    <= (next_state_s != IDLE);
            penable_r <= (next_state_s == ACCESS);
            done_r    <= {NREQ{1'b0}};
            if (state_r == IDLE && win_valid_s) begin
                grant_r      <= win_idx_s;
                last_grant_r <= win_idx_s;
                paddr_r      <= req_addr[win_idx_s*AW +: AW];
                pwrite_r     <= req_write[win_idx_s];
                pwdata_r     <= req_write[win_idx_s] ? req_wdata[win_idx_s*DW +: DW] : {DW{1'b0}};
            end
            if (complete_s) begin
                done_r[grant_r] <= 1'b1;
                if (timeout_s) begin
                    rdata_r <= {DW{1'b0}};
                    err_r   <= 1'b1;
                end else begin
                    rdata_r <= pwrite_r ? {DW{1'b0}} : apb.prdata;
                    err_r   <= apb.pslverr;
                end
            end
        end
    end

    assign apb.psel    = psel_r;
    assign apb.penable = penable_r;
    assign apb.pwrite  = pwrite_r;
    assign apb.paddr   = paddr_r;
    assign apb.pwdata  = pwdata_r;
    assign done        = done_r;
    assign rdata       = rdata_r;
    assign err         = err_r;
endmodule

// File: doc/apb_master_arb.md
# apb_master_arb

Round-robin arbiter and APB3 master sequencer that shares one APB bus between NREQ local requesters. It sits between the bus-side requesters (register-access engines, test stimulus agents) and the APB slave fabric. The APB signals it drives are the ones the team's APB coverage module samples. It owns the IDLE/SETUP/ACCESS phase sequencing, one transfer at a time, and returns read data and error status to the granted requester.

## Interface
- NREQ, 4, number of requesters (2..8)
- AW, 32, address width
- DW, 32, data width
- TIMEOUT, 16, max ACCESS cycles with pready low before abort (used only with APB_ARB_TIMEOUT_EN)

Ports:
- clk  in  1  clock; all logic rising-edge
- rst  in  1  reset, asynchronous, active-high
- req  in  NREQ  per-requester transfer request; held until own done
- req_addr  in  NREQ*AW  requester i at [i*AW +: AW]
- req_write  in  NREQ  1 = write
- req_wdata  in  NREQ*DW  requester i at [i*DW +: DW]
- done  out  NREQ  one-cycle completion pulse to the granted requester
- rdata  out  DW  read data, valid while any done bit is high
- err  out  1  pslverr/timeout status, valid while any done bit is high
- psel, penable, pwrite  out  1  APB control
- paddr  out  AW  APB address
- pwdata  out  DW  APB write data
- prdata  in  DW  APB read data
- pready, pslverr  in  1  APB slave response

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- IDLE -> SETUP when any eligible req is high. Eligible means req[i] high and done[i] low.
- SETUP -> ACCESS unconditionally.
- ACCESS -> IDLE on pready. Otherwise stay in ACCESS.
- Arbitration runs only in IDLE. The search starts at last_grant+1 and wraps modulo NREQ. The first eligible requester wins, and last_grant updates to the winner.
- On the IDLE->SETUP edge, paddr, pwrite and pwdata are registered from the winner and held constant through ACCESS. pwdata = 0 for reads.
- psel = 1 in SETUP and ACCESS. penable = 1 in ACCESS only.
- Completion in ACCESS with pready=1:
  - next cycle done[grant]=1 for exactly one cycle;
  - rdata = prdata captured for reads, 0 for writes;
  - err = captured pslverr.
- Requesters must drop or renew req in the cycle done is high. Masking done[i] from eligibility prevents a stale re-grant.
- Requester inputs are ignored outside the IDLE arbitration point. Changing a request while it is in flight is a requester protocol error and has no effect.

## Timing
- Reset values: state=IDLE, last_grant=NREQ-1 (requester 0 wins first), psel=penable=pwrite=0, paddr=pwdata=0, done=0, rdata=0, err=0, timeout counter=0.
- rst asserted mid-transfer: all outputs clear immediately (async). The transfer is dropped and no done is issued.
- Latency with zero-wait slave: req seen in IDLE at cycle 0 -> SETUP cycle 1 -> ACCESS cycle 2 -> done at cycle 3.
- Each wait state adds one cycle.
- Minimum 3 cycles per transfer. The bus returns to IDLE between transfers, and done coincides with that IDLE cycle.
- Simultaneous requests: strict round-robin, so no requester waits more than NREQ-1 transfers.
- Wrap: after a grant to NREQ-1, the search starts at 0.

## Configuration
- Macro APB_ARB_TIMEOUT_EN.
- Defined:
  - a counter increments each ACCESS cycle with pready=0;
  - if pready is still 0 in the TIMEOUT-th ACCESS cycle, the FSM forces ACCESS -> IDLE and psel/penable drop;
  - next cycle done pulses with err=1 and rdata=0;
  - the counter clears on every SETUP.
- Undefined: no counter exists, ACCESS waits indefinitely, and TIMEOUT is ignored.

## Test plan
- Reset release, requester 0 writes addr 0x10, data 0xA5A5_0001, slave pready=1 -> psel at cycle 1, penable at cycle 2, done[0] at cycle 3, err=0.
- Requester 2 reads addr 0x24, slave inserts 2 wait states, returns prdata 0xDEAD_BEEF -> done[2] at cycle 5 with rdata 0xDEAD_BEEF.
- All 4 requesters request together and hold request until served -> grant order 0,1,2,3, then 0 again on re-request. paddr never changes within a transfer.
- Slave returns pslverr=1 on requester 1's write -> done[1] with err=1; the next transfer shows err=0.
- Reset asserted during ACCESS of requester 3 -> psel, penable and done go to 0 immediately. After release, requester 0 is granted first.
- With APB_ARB_TIMEOUT_EN, TIMEOUT=16 and pready tied low -> psel drops after 16 ACCESS cycles, then done pulses with err=1 and rdata=0. Without the macro the bench confirms psel stays high for 100 cycles.
